// File: rtl/vga_timing_gen.sv
// Pixel-timing generator: sync, active-video and coordinates advanced by a pixel strobe.
// Optional completed-frame counter enabled by defining VGA_TIMING_FRAMECNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic             ACT      = (SYNC_POL != 0);

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             frame_wrap;
  logic             hs_act;
  logic             vs_act;
  logic             vid_next;

  always_comb begin
    h_next     = x;
    v_next     = y;
    frame_wrap = 1'b0;
    if (pix_en) begin
      if (x == H_LAST) begin
        h_next = '0;
        if (y == V_LAST) begin
          v_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          v_next = y + ONE;
        end
      end else begin
        h_next = x + ONE;
      end
    end
  end

  // Flags are decoded from the next coordinates so they register alongside x/y.
  always_comb begin
    hs_act   = (h_next >= HS_START) && (h_next < HS_END);
    vs_act   = (v_next >= VS_START) && (v_next < VS_END);
    vid_next = (h_next < H_VIS) && (v_next < V_VIS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      hsync       <= ~ACT;
      vsync       <= ~ACT;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= h_next;
      y           <= v_next;
      hsync       <= hs_act ? ACT : ~ACT;
      vsync       <= vs_act ? ACT : ~ACT;
      video_on    <= vid_next;
      frame_start <= frame_wrap;
    end
  end

`ifdef VGA_TIMING_FRAMECNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= 8'd0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = 8'd0;
`endif

endmodule
